// File: rtl/nand_phy_pkg.sv
// Shared types and constants for the NV-DDR NAND PHY write sequencer.
package nand_phy_pkg;

  localparam int unsigned CYC_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_BURST,
    ST_POST,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/nand_phy_cyc_timer.sv
// Small load/decrement cycle timer with a zero flag, used for both preamble and postamble.
module nand_phy_cyc_timer
  import nand_phy_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CYC_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CYC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nand_phy_dqs_wr_seq.sv
// Write-direction DQS/DQ sequencer: preamble, N toggling beats with underrun pauses, postamble.
module nand_phy_dqs_wr_seq
  import nand_phy_pkg::*;
#(
  parameter int unsigned DQ_WIDTH = 8,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PRE_CYC  = 2,
  parameter int unsigned POST_CYC = 2
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic                cmd_valid,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                cmd_ready,
  input  logic                wr_valid,
  input  logic [DQ_WIDTH-1:0] wr_rise,
  input  logic [DQ_WIDTH-1:0] wr_fall,
  output logic                wr_ready,
  output logic [DQ_WIDTH-1:0] dq_rise,
  output logic [DQ_WIDTH-1:0] dq_fall,
  output logic                dq_oe_n,
  output logic                dqs_oe_n,
  output logic                dqs_rst_n,
  output logic                burst_done,
  output logic [7:0]          underrun_cnt
);

  wr_state_e        state_q;
  logic [LEN_W-1:0] beats_q;
  logic             accept, hs, last_beat;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [CYC_W-1:0] tmr_val;

  assign accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
  assign hs        = (state_q == ST_BURST) && wr_valid && wr_ready;
  assign last_beat = hs && (beats_q == LEN_W'(1));

  // One timer serves both phases: loaded on entry to PRE and on the last beat for POST.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = CYC_W'(PRE_CYC - 1);
    end else if (last_beat) begin
      tmr_load = 1'b1;
      tmr_val  = CYC_W'(POST_CYC - 1);
    end
    tmr_dec = (state_q == ST_PRE) || (state_q == ST_POST);
  end

  nand_phy_cyc_timer u_timer (
    .clk_i      (clk0),
    .rst_i      (rst0),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q      <= ST_IDLE;
      beats_q      <= '0;
      cmd_ready    <= 1'b0;
      wr_ready     <= 1'b0;
      dq_rise      <= '0;
      dq_fall      <= '0;
      dq_oe_n      <= 1'b1;
      dqs_oe_n     <= 1'b1;
      dqs_rst_n    <= 1'b0;
      burst_done   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      burst_done <= 1'b0;
      dqs_rst_n  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready    <= 1'b0;
            underrun_cnt <= '0;
            if (cmd_len == '0) begin
              state_q    <= ST_DONE;
              burst_done <= 1'b1;
            end else begin
              state_q  <= ST_PRE;
              beats_q  <= cmd_len;
              dqs_oe_n <= 1'b0;
              dq_oe_n  <= 1'b0;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_PRE: begin
          if (tmr_zero) begin
            state_q  <= ST_BURST;
            wr_ready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (hs) begin
            dq_rise   <= wr_rise;
            dq_fall   <= wr_fall;
            dqs_rst_n <= 1'b1;
            beats_q   <= beats_q - LEN_W'(1);
            if (last_beat) begin
              state_q  <= ST_POST;
              wr_ready <= 1'b0;
            end
          end else if (underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
        ST_POST: begin
          if (tmr_zero) begin
            state_q    <= ST_DONE;
            dqs_oe_n   <= 1'b1;
            dq_oe_n    <= 1'b1;
            burst_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_phy_dqs_wr_seq.sv
// Randomized bench for nand_phy_dqs_wr_seq against a counter-based behavioural model.
module tb_nand_phy_dqs_wr_seq;

  localparam int DQW  = 8;
  localparam int LW   = 16;
  localparam int PRE  = 2;
  localparam int POST = 2;

  logic          clk0, rst0;
  logic          cmd_valid, cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DQW-1:0] wr_rise, wr_fall, dq_rise, dq_fall;
  logic          dq_oe_n, dqs_oe_n, dqs_rst_n, burst_done;
  logic [7:0]    underrun_cnt;

  nand_phy_dqs_wr_seq #(.DQ_WIDTH(DQW), .LEN_W(LW), .PRE_CYC(PRE), .POST_CYC(POST)) dut (
    .clk0(clk0), .rst0(rst0), .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .wr_valid(wr_valid), .wr_rise(wr_rise), .wr_fall(wr_fall), .wr_ready(wr_ready),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .dq_oe_n(dq_oe_n), .dqs_oe_n(dqs_oe_n),
    .dqs_rst_n(dqs_rst_n), .burst_done(burst_done), .underrun_cnt(underrun_cnt)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Model: remaining PRE cycles, beats and POST cycles describe where the burst is.
  bit         m_valid = 0;
  int         m_pre = 0, m_beats = 0, m_post = 0;
  int         acc_cnt = 0;
  logic       e_cmd_ready, e_wr_ready, e_oe_n, e_dqs_rst_n, e_done;
  logic [7:0] e_dq_rise, e_dq_fall, e_under;

  always @(negedge clk0) begin : model
    logic hs, nd, nrst;
    if (m_valid)
      chk("outputs",
          {cmd_ready, wr_ready, dq_rise, dq_fall, dq_oe_n, dqs_oe_n, dqs_rst_n, burst_done, underrun_cnt},
          {e_cmd_ready, e_wr_ready, e_dq_rise, e_dq_fall, e_oe_n, e_oe_n, e_dqs_rst_n, e_done, e_under});
    if (rst0) begin
      m_valid = 1; m_pre = 0; m_beats = 0; m_post = 0;
      e_cmd_ready = 0; e_wr_ready = 0; e_oe_n = 1; e_dqs_rst_n = 0; e_done = 0;
      e_dq_rise = '0; e_dq_fall = '0; e_under = '0;
    end else if (m_valid) begin
      hs = wr_valid && e_wr_ready;
      nd = 0; nrst = 0;
      if (e_cmd_ready && cmd_valid) begin
        acc_cnt++;
        e_under = '0;
        if (cmd_len == 0) nd = 1;
        else begin m_pre = PRE; m_beats = int'(cmd_len); end
      end else if (m_pre > 0) begin
        m_pre--;
      end else if (m_beats > 0) begin
        if (hs) begin
          e_dq_rise = wr_rise; e_dq_fall = wr_fall; nrst = 1; m_beats--;
          if (m_beats == 0) m_post = POST;
        end else if (e_under < 8'd255) begin
          e_under = e_under + 8'd1;
        end
      end else if (m_post > 0) begin
        m_post--;
        if (m_post == 0) nd = 1;
      end
      e_done      = nd;
      e_dqs_rst_n = nrst;
      e_oe_n      = !(m_pre > 0 || m_beats > 0 || m_post > 0);
      e_wr_ready  = (m_pre == 0 && m_beats > 0);
      e_cmd_ready = e_oe_n && !nd;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic wait_accept(output bit ok);
    int a0, k;
    a0 = acc_cnt; k = 0;
    do begin tick(); k++; end while (acc_cnt == a0 && k < 100);
    ok = (acc_cnt != a0);
    chk("accept_seen", ok, 1);
  endtask

  // Per-burst statistics gathered from the DUT outputs by run_cmd.
  int         st_k_done, st_oe_low, st_n, st_pauses, st_dq_n, st_seq_cnt, st_done_tick, st_acc_tick;
  logic [7:0] st_under;
  logic [7:0] st_dq[8];
  logic       st_seq[16];
  logic       st_oe_at_done, st_hold_ok;

  task automatic run_cmd(input int len, input int mode, input int pct, input bit hold, input int next_len);
    int n, k, paused, last_pn;
    bit hs_p, ok, got_done, seen1;
    logic [7:0] last_dq;
    st_k_done = -1; st_oe_low = 0; st_pauses = 0; st_dq_n = 0; st_seq_cnt = 0;
    st_under = '0; st_oe_at_done = 0; st_hold_ok = 1;
    n = 0; k = 0; paused = 0; last_pn = -1; hs_p = 0; got_done = 0; seen1 = 0; last_dq = '0;
    cmd_valid = 1; cmd_len = LW'(len); wr_valid = 0;
    wait_accept(ok);
    st_acc_tick = cyc;
    if (hold) cmd_len = LW'(next_len);
    else cmd_valid = 0;
    if (ok) begin
      while (!got_done && k < 2 * len + 600) begin
        if (hs_p) n++;
        if (burst_done) begin
          got_done = 1; st_k_done = k; st_under = underrun_cnt;
          st_oe_at_done = dqs_oe_n; st_done_tick = cyc;
        end else begin
          if (!dqs_oe_n || !dq_oe_n) st_oe_low++;
          if (dqs_rst_n) begin
            seen1 = 1;
            if (st_dq_n < 8) st_dq[st_dq_n] = dq_rise;
            st_dq_n++;
            last_dq = dq_rise;
          end else if (seen1 && dq_rise !== last_dq) begin
            st_hold_ok = 0;
          end
          if (seen1 && st_seq_cnt < 16) begin st_seq[st_seq_cnt] = dqs_rst_n; st_seq_cnt++; end
          case (mode)
            0: wr_valid = 1;
            1: if (n == 1 && paused < 2) begin wr_valid = 0; paused++; end else wr_valid = 1;
            2: wr_valid = (int'($urandom_range(1, 100)) <= pct);
            default: if (n % 200 == 100 && last_pn != n && paused < 300) begin
                wr_valid = 0; last_pn = n; paused++;
              end else wr_valid = 1;
          endcase
          if (mode == 2) begin wr_rise = 8'($urandom); wr_fall = 8'($urandom); end
          else begin wr_rise = 8'(8'hA0 + n); wr_fall = 8'(8'h50 + n); end
          if (wr_ready && !wr_valid) st_pauses++;
          hs_p = wr_valid && wr_ready;
          tick(); k++;
        end
      end
      chk("burst_done_seen", got_done, 1);
    end
    wr_valid = 0;
    st_n = n;
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok, hs_p;
    int n, k, cnt, d1, exp_k;
    rst0 = 1; cmd_valid = 0; cmd_len = '0; wr_valid = 0; wr_rise = '0; wr_fall = '0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_dqs_oe_n", dqs_oe_n, 1);
    chk("rst_dqs_rst_n", dqs_rst_n, 0);
    chk("rst_underrun", underrun_cnt, 0);
    rst0 = 0;
    tick();
    chk("ready_after_reset", cmd_ready, 1);

    // Full-rate burst of 4 beats.
    run_cmd(4, 0, 0, 0, 0);
    chk("t1_oe_low_cycles", st_oe_low, 8);
    chk("t1_beats_out", st_dq_n, 4);
    for (int i = 0; i < 4; i++) chk("t1_dq_order", st_dq[i], 8'hA0 + 8'(i));
    chk("t1_done_offset", st_k_done, PRE + 4 + POST);
    chk("t1_oe_high_at_done", st_oe_at_done, 1);
    chk("t1_handshakes", st_n, 4);

    // Two-cycle underrun after the first beat.
    run_cmd(3, 1, 0, 0, 0);
    chk("t2_dqs_pattern", {st_seq[0], st_seq[1], st_seq[2], st_seq[3], st_seq[4]}, 5'b10011);
    chk("t2_dq_hold", st_hold_ok, 1);
    chk("t2_underrun", st_under, 2);
    chk("t2_handshakes", st_n, 3);
    chk("t2_done_offset", st_k_done, PRE + 3 + 2 + POST);

    // Zero-length command.
    run_cmd(0, 0, 0, 0, 0);
    chk("t3_done_next", st_k_done, 0);
    chk("t3_oe_never_low", st_oe_low, 0);

    // Reset in the middle of an 8-beat burst.
    cmd_valid = 1; cmd_len = 16'd8;
    wait_accept(ok);
    cmd_valid = 0; n = 0; k = 0; hs_p = 0;
    while (k < 50) begin
      if (hs_p) n++;
      hs_p = 0;
      if (n >= 2) break;
      wr_valid = 1; wr_rise = 8'(8'h10 + n); wr_fall = 8'(8'h20 + n);
      hs_p = wr_valid && wr_ready;
      tick(); k++;
    end
    chk("t4_two_beats", n, 2);
    rst0 = 1;
    tick();
    chk("t4_rst_dqs_oe_n", dqs_oe_n, 1);
    chk("t4_rst_dq_oe_n", dq_oe_n, 1);
    chk("t4_rst_wr_ready", wr_ready, 0);
    chk("t4_rst_dq_rise", dq_rise, 0);
    rst0 = 0; wr_valid = 0; cnt = 0;
    repeat (5) begin tick(); if (burst_done) cnt++; end
    chk("t4_no_done", cnt, 0);
    run_cmd(2, 0, 0, 0, 0);
    chk("t4_after_underrun", st_under, 0);
    chk("t4_after_beats", st_n, 2);
    chk("t4_after_done_offset", st_k_done, PRE + 2 + POST);

    // cmd_valid held high: length 1 then length 2.
    run_cmd(1, 0, 0, 1, 2);
    d1 = st_done_tick;
    chk("t5_first_beats", st_n, 1);
    run_cmd(2, 0, 0, 0, 0);
    chk("t5_accept_gap", st_acc_tick - d1, 2);
    chk("t5_second_beats", st_n, 2);

    // Randomized bursts with random underruns.
    for (int i = 0; i < 20; i++) begin
      int len, pct;
      len = int'($urandom_range(0, 12));
      pct = int'($urandom_range(30, 100));
      run_cmd(len, 2, pct, 0, 0);
      chk("rnd_beats", st_n, len);
      chk("rnd_underrun", st_under, (st_pauses > 255) ? 255 : st_pauses);
      exp_k = (len == 0) ? 0 : PRE + len + POST + st_pauses;
      chk("rnd_done_offset", st_k_done, exp_k);
    end

    // Maximum length with 300 spread pauses.
    run_cmd(65535, 3, 0, 0, 0);
    chk("t6_beats", st_n, 65535);
    chk("t6_pauses", st_pauses, 300);
    chk("t6_underrun_sat", st_under, 255);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
